// File: rtl/dcpu_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcpu_dbg_pkg
//  Purpose  : Shared types and constants for the DCPU run-control block.
//             - dbg_state_e : run-control FSM state encoding
//             - CYC_W       : width of the completed-CPU-cycle counter
//  Revision : 1.0 - initial release
// ============================================================================
package dcpu_dbg_pkg;

  localparam int CYC_W = 32;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } dbg_state_e;

endpackage : dcpu_dbg_pkg
`default_nettype wire

// File: rtl/dcpu_dbg_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Two-flop synchroniser, stability filter and rising-edge pulse
//             for a raw mechanical push button.
//  Ports    : clk_in  - board clock
//             reset   - asynchronous, active-high
//             btn_raw - raw, asynchronous button level
//             btn_pls - one-cycle pulse per accepted 0->1 transition
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DB_LOG2 = 20
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pls
);

  logic [1:0]         sync_q,   sync_d;
  logic               stable_q, stable_d;
  logic [DB_LOG2-1:0] db_cnt_q, db_cnt_d;
  logic               pls_q,    pls_d;

  // The stability counter only runs while the synchronised level differs from
  // the accepted level. Any return to the accepted level (a bounce) clears it,
  // so a new level is accepted only after 2^DB_LOG2 consecutive cycles.
  always_comb begin
    sync_d   = {sync_q[0], btn_raw};
    stable_d = stable_q;
    db_cnt_d = '0;
    pls_d    = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (&db_cnt_q) begin
        stable_d = sync_q[1];
        pls_d    = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
      pls_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      pls_q    <= pls_d;
    end
  end

  assign btn_pls = pls_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/dcpu_dbg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dcpu_dbg_ctrl
//  Purpose  : Board-level run control and display selection for the DCPU.
//             Generates the divided CPU clock with free-run / halt /
//             single-step / PC-breakpoint modes, counts completed CPU cycles
//             and registers one debug channel for the 7-segment driver.
//  Ports    : clk_in, reset        - board clock, async active-high reset
//             run_sw, step_btn     - raw run switch and step button
//             bp_en, bp_addr, pc   - breakpoint enable/address, CPU PC
//             ch_data, ch_sel      - packed debug channels and selector
//             clk_cpu              - divided CPU clock
//             halted, bp_hit       - run-control status
//             cyc_cnt              - completed CPU cycles (mod 2^32)
//             disp_data            - registered selected channel
//  Revision : 1.0 - initial release
// ============================================================================
module dcpu_dbg_ctrl
  import dcpu_dbg_pkg::*;
#(
  parameter int DIV_LOG2 = 14,
  parameter int DB_LOG2  = 20,
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 32
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       run_sw,
  input  logic                       step_btn,
  input  logic                       bp_en,
  input  logic [DATA_W-1:0]          bp_addr,
  input  logic [DATA_W-1:0]          pc,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic [$clog2(NUM_CH)-1:0]  ch_sel,
  output logic                       clk_cpu,
  output logic                       halted,
  output logic                       bp_hit,
  output logic [CYC_W-1:0]           cyc_cnt,
  output logic [DATA_W-1:0]          disp_data
);

  localparam int SEL_W = $clog2(NUM_CH);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [1:0] run_sync_q, run_sync_d;
  logic       run_prev_q, run_prev_d;
  logic       run_rise;
  logic       step_pls;

  assign run_sync_d = {run_sync_q[0], run_sw};
  assign run_prev_d = run_sync_q[1];
  assign run_rise   = run_sync_q[1] & ~run_prev_q;

  btn_debounce #(
    .DB_LOG2 (DB_LOG2)
  ) u_step_db (
    .clk_in  (clk_in),
    .reset   (reset),
    .btn_raw (step_btn),
    .btn_pls (step_pls)
  );

  // --------------------------------------------------------------------------
  // Divider and run-control FSM
  // --------------------------------------------------------------------------
  dbg_state_e          state_q, state_d;
  logic [DIV_LOG2:0]   cnt_q,   cnt_d;
  logic [CYC_W-1:0]    cyc_q,   cyc_d;
  logic                counting;
  logic                wrap;
  logic                bp_match;

  assign counting = (state_q == ST_RUN) || (state_q == ST_STEP);
  // A wrap is the last clk_in cycle of a CPU period; every state change out of
  // RUN/STEP is gated on it so clk_cpu never gets a truncated phase, and cnt
  // is always back at zero whenever the FSM is in HALT or BREAK.
  assign wrap     = counting && (&cnt_q);
  // pc is sampled in the wrap cycle, half a CPU period after its last change.
  assign bp_match = bp_en && (pc == bp_addr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT, ST_BREAK: begin
        if (run_rise) begin
          state_d = ST_RUN;
        end else if (step_pls) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (wrap) begin
          if (bp_match) begin
            state_d = ST_BREAK;
          end else if (!run_sync_q[1]) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_STEP: begin
        if (wrap) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    if (counting) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (wrap) begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Display channel select; out-of-range selects read as zero
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] disp_q, disp_d;

  always_comb begin
    disp_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel == SEL_W'(k)) begin
        disp_d = ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      run_sync_q <= '0;
      run_prev_q <= 1'b0;
      state_q    <= ST_HALT;
      cnt_q      <= '0;
      cyc_q      <= '0;
      disp_q     <= '0;
    end else begin
      run_sync_q <= run_sync_d;
      run_prev_q <= run_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      disp_q     <= disp_d;
    end
  end

  // Straight from flops: reset clears cnt_q asynchronously, so clk_cpu drops
  // immediately, and the status bits have no path from the inputs.
  assign clk_cpu   = cnt_q[DIV_LOG2];
  assign halted    = (state_q == ST_HALT) || (state_q == ST_BREAK);
  assign bp_hit    = (state_q == ST_BREAK);
  assign cyc_cnt   = cyc_q;
  assign disp_data = disp_q;

endmodule : dcpu_dbg_ctrl
`default_nettype wire

// File: doc/dcpu_dbg_ctrl.md
# dcpu_dbg_ctrl

Board-level run-control and display block for the DCPU. It generates the divided CPU clock with free-run, halt, single-step and PC-breakpoint modes, counts completed CPU cycles, and selects one of `NUM_CH` 32-bit debug channels for the 7-segment driver. It sits between the board I/O and `dcpu_top`/`seg7x16`.

## Interface
- `DIV_LOG2`, 14: `clk_cpu` period is 2^(DIV_LOG2+1) `clk_in` cycles.
- `DB_LOG2`, 20: the step button must be stable for 2^DB_LOG2 cycles to be accepted.
- `NUM_CH`, 4: number of display channels (≥2).
- `DATA_W`, 32: channel, pc and breakpoint width.
- `clk_in` in 1: board clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `run_sw` in 1: raw run switch (level).
- `step_btn` in 1: raw single-step button.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in DATA_W: breakpoint PC.
- `pc` in DATA_W: CPU PC (changes on `clk_cpu` rising edge).
- `ch_data` in NUM_CH*DATA_W: channel k at bits [k*DATA_W +: DATA_W].
- `ch_sel` in $clog2(NUM_CH): display channel select.
- `clk_cpu` out 1: divided CPU clock.
- `halted` out 1: high in HALT or BREAK.
- `bp_hit` out 1: high in BREAK.
- `cyc_cnt` out 32: completed CPU cycles.
- `disp_data` out DATA_W: registered selected channel.

## Operation
- `run_sw` and `step_btn` each pass through a 2-flop synchroniser. `run_rise` is a rising edge of synced `run_sw`. `step_btn` is then debounced; `step_pls` is a one-cycle pulse on each accepted 0→1 transition.
- Divider `cnt` has DIV_LOG2+1 bits. `clk_cpu = cnt[DIV_LOG2]`. `cnt` increments only in RUN or STEP and holds in HALT or BREAK. "wrap" means `cnt` is all-ones and increments this cycle, i.e. one full CPU cycle has completed.
- FSM states: HALT, RUN, STEP, BREAK. Reset state is HALT.
  - HALT: `run_rise` → RUN; else `step_pls` → STEP.
  - RUN: at wrap, `bp_en && pc==bp_addr` → BREAK; else synced `run_sw`==0 → HALT; else stay in RUN. No exit is possible except at wrap.
  - STEP: at wrap → HALT, so exactly one full `clk_cpu` period is produced.
  - BREAK: `run_rise` → RUN; else `step_pls` → STEP.
- Halting occurs only at wrap, so `clk_cpu` never has a truncated high or low phase.
- `step_pls` in RUN or STEP is dropped. `run_rise` in STEP is ignored.
- If `run_sw` is still high after a step, the state returns to HALT; a fresh `run_rise` is needed to resume.
- `cyc_cnt` increments by 1 at every wrap and wraps modulo 2^32.
- `disp_data` <= slice `ch_sel` of `ch_data` every cycle. It is 0 if `ch_sel` ≥ NUM_CH.
- Reset values: `cnt`=0, `clk_cpu`=0, state=HALT, `halted`=1, `bp_hit`=0, `cyc_cnt`=0, `disp_data`=0, synchronisers and debounce counter=0.

## Timing
- `halted` and `bp_hit` are decoded from registered state, with no combinational path from inputs.
- Raw button to `step_pls`: 2 cycles of synchroniser plus 2^DB_LOG2 cycles of stability. A bounce restarts the stability count.
- `step_pls` in cycle t → STEP in t+1 with `cnt`=0.
  - `clk_cpu` rises at t+1+2^DIV_LOG2.
  - The FSM is in HALT at t+1+2^(DIV_LOG2+1).
- The breakpoint compare uses `pc` sampled in the wrap cycle. `pc` is then stable, one half-period after the rising edge.
- Resuming from BREAK does not immediately re-break, because the next compare follows a new rising edge.
- `disp_data` latency is 1 cycle.
- Asynchronous `reset` mid-period forces `clk_cpu` low immediately.

## Structure
- Package `dcpu_dbg_pkg` holds the state enum (`ST_HALT`, `ST_RUN`, `ST_STEP`, `ST_BREAK`) and the `CYC_W`=32 constant.
- One sub-module, `btn_debounce` (param `DB_LOG2`), contains the synchroniser, stability counter and rising-edge pulse.

## Test plan
All scenarios use DIV_LOG2=2 (period 8) and DB_LOG2=3.
- Reset, then `run_sw` 0→1 → RUN. `clk_cpu` is 4 low / 4 high. After 80 cycles `cyc_cnt`=10.
- While running, drop `run_sw` in the middle of a high phase → the high phase completes, `halted`=1 at the next wrap, and `cnt`=0.
- From HALT, press `step_btn` cleanly → exactly one `clk_cpu` pulse, `cyc_cnt` +1, back to HALT.
- Press `step_btn` with 3-cycle bounces → no step until the input has been stable for 8 cycles, then exactly one step.
- `bp_en`=1, `bp_addr`=0x0C, `pc` model +4 per `clk_cpu` rise from 0 → BREAK with `cyc_cnt`=3 and `bp_hit`=1.
  - A step from BREAK → `pc`=0x10, HALT.
  - `run_rise` then → RUN.
- `ch_sel` sweeps 0..3 with distinct values (e.g. 0xA0A0_0001…) → `disp_data` matches one cycle later. With NUM_CH=3 and `ch_sel`=3 → 0.
- Assert `reset` mid-STEP → `clk_cpu`=0, HALT, `cyc_cnt`=0 immediately.
